// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, constants and the fetch FSM state type.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;
    localparam logic [ILEN-1:0] NOP     = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    // Instruction addresses are always word aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] p);
        return {p[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory request/response, redirect and decode handshakes.
// The master modport is the fetch side; the slave modport is memory/execute/decode.
interface fetch_unit_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [ILEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
               redirect_valid, redirect_pc, instr_ready
    );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO holding {instruction, pc} entries for decode.
// Flush empties the queue and wins over a push or pop in the same cycle.
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0) && !flush;
    assign do_push = push && !flush;
    assign head    = (count != '0) ? mem[rd_ptr] : '0;

    // Storage array; only written on an accepted push.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush and reset both return to empty.
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // The fetch credit rule makes overflow impossible; flag it if it ever happens.
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(do_push && !do_pop && count == DEPTH_C));
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Keeps the PC, issues in-order word reads, queues returned words with their PC,
// and on a redirect flushes the queue and drops responses from the old path.
// Define FETCH_PERF_EN to add the saturating stall_cycles counter and port.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
    parameter int              QUEUE_DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    fetch_state_t state, state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ret_pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   drop_cnt, drop_cnt_next;
    logic [CW-1:0]   count;
    logic            redirect;
    logic            req_valid;
    logic            req_fire;
    logic            resp_dec;
    logic            resp_keep;
    logic            pop;
    logic [ILEN+XLEN-1:0] head;

    assign redirect  = bus.redirect_valid;
    assign target    = align_pc(bus.redirect_pc);
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign resp_dec  = bus.imem_resp_valid && (outstanding != '0);
    assign resp_keep = resp_dec && (state == RUN) && !redirect;
    assign pop       = bus.instr_valid && bus.instr_ready && !redirect;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.instr_valid    = !reset && (count != '0);
    assign bus.instr          = head[ILEN+XLEN-1:XLEN];
    assign bus.instr_pc       = head[XLEN-1:0];

    // Request credit and RUN/DRAIN transitions; a redirect reloads the drop count from
    // what will still be in flight once this cycle's response has landed.
    always_comb begin
        state_next    = state;
        drop_cnt_next = drop_cnt;
        req_valid     = 1'b0;
        if (!reset && state == RUN && !redirect && (outstanding + count) < DEPTH_C) begin
            req_valid = 1'b1;
        end
        if (redirect) begin
            drop_cnt_next = outstanding - CW'(resp_dec);
            state_next    = (drop_cnt_next != '0) ? DRAIN : RUN;
        end else if (state == DRAIN) begin
            if (resp_dec) drop_cnt_next = drop_cnt - CW'(1);
            if (drop_cnt_next == '0) state_next = RUN;
        end
    end

    // State register plus fetch PC, return-PC tracker and in-flight counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            drop_cnt    <= '0;
            outstanding <= '0;
            pc          <= RESET_PC;
            ret_pc      <= RESET_PC;
        end else begin
            state       <= state_next;
            drop_cnt    <= drop_cnt_next;
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_dec);
            if (redirect) begin
                pc     <= target;
                ret_pc <= target;
            end else begin
                if (req_fire)  pc     <= pc + PC_STEP;
                if (resp_keep) ret_pc <= ret_pc + PC_STEP;
            end
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (ILEN + XLEN)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (resp_keep),
        .push_data ({bus.imem_resp_data, ret_pc}),
        .pop       (pop),
        .flush     (redirect),
        .head      (head),
        .count     (count)
    );

`ifdef FETCH_PERF_EN
    // Count RUN cycles in which decode is starved, saturating at all ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (state == RUN && !bus.instr_valid && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a one-cycle in-order memory model.
// Define FETCH_PERF_EN to also exercise the stall counter.
module tb_fetch_unit;
    import riscv_pkg::*;

    logic clock;
    logic reset;
    logic resp_en;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [31:0] pend [$];

`ifdef FETCH_PERF_EN
    logic [31:0] stall_cycles;
`endif

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC    (32'h0000_0000),
        .QUEUE_DEPTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
`ifdef FETCH_PERF_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // One-cycle memory: a request accepted at an edge is answered in the next cycle.
    initial begin : mem_model
        bit          fire_now;
        bit          resp_now;
        logic [31:0] addr_now;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(negedge clock);
            #2;
            fire_now = !reset && bus.imem_req_valid && bus.imem_req_ready;
            resp_now = bus.imem_resp_valid;
            addr_now = bus.imem_req_addr;
            @(posedge clock);
            #1;
            if (reset) begin
                pend.delete();
            end else begin
                if (resp_now && pend.size() > 0) void'(pend.pop_front());
                if (fire_now) pend.push_back(addr_now);
            end
            if (!reset && resp_en && pend.size() > 0) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = memword(pend[0]);
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = '0;
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reset with default inputs; returns at the negedge where reset drops.
    task automatic do_reset();
        @(negedge clock);
        reset              = 1'b1;
        resp_en            = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset              = 1'b1;
        resp_en            = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.instr_ready    = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        vectors++;
        if (bus.imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_req_valid: got %b expected 0", bus.imem_req_valid);
        end
        vectors++;
        if (bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_instr_valid: got %b expected 0", bus.instr_valid);
        end
        vectors++;
        if (bus.instr !== 32'h0 || bus.instr_pc !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_head: got instr %h pc %h expected 0 0", bus.instr, bus.instr_pc);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        vectors++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_first_req: got valid %b addr %h expected 1 00000000",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset();
        #1;
        vectors++;
        if (bus.imem_req_addr !== 32'h0 || bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL stream_c1: got addr %h ivalid %b expected 00000000 0",
                     bus.imem_req_addr, bus.instr_valid);
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            #1;
            vectors++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'(4 * k)) begin
                miscompares++;
                $display("[TB] FAIL stream_addr[%0d]: got valid %b addr %h expected 1 %h",
                         k, bus.imem_req_valid, bus.imem_req_addr, 32'(4 * k));
            end
            if (k == 1) begin
                vectors++;
                if (bus.instr_valid !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL stream_early_valid: got %b expected 0", bus.instr_valid);
                end
            end else begin
                exp_pc = 32'(4 * (k - 2));
                vectors++;
                if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp_pc || bus.instr !== memword(exp_pc)) begin
                    miscompares++;
                    $display("[TB] FAIL stream_head[%0d]: got v %b pc %h instr %h expected 1 %h %h",
                             k, bus.instr_valid, bus.instr_pc, bus.instr, exp_pc, memword(exp_pc));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_pc;
        do_reset();
        bus.instr_ready = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clock);
                #1;
            end
            vectors++;
            if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'(4 * k)) begin
                miscompares++;
                $display("[TB] FAIL bp_req[%0d]: got valid %b addr %h expected 1 %h",
                         k, bus.imem_req_valid, bus.imem_req_addr, 32'(4 * k));
            end
        end
        for (int k = 4; k <= 6; k++) begin
            @(negedge clock);
            #1;
            vectors++;
            if (bus.imem_req_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL bp_no_req[%0d]: got %b expected 0", k, bus.imem_req_valid);
            end
        end
        vectors++;
        if (dut.count !== 3'd4 || bus.instr_pc !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL bp_full: got count %0d pc %h expected 4 00000000", dut.count, bus.instr_pc);
        end
        @(negedge clock);
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clock);
            #1;
            exp_pc = 32'(4 * k);
            vectors++;
            if (bus.instr_valid !== 1'b1 || bus.instr_pc !== exp_pc) begin
                miscompares++;
                $display("[TB] FAIL bp_drain[%0d]: got v %b pc %h expected 1 %h",
                         k, bus.instr_valid, bus.instr_pc, exp_pc);
            end
        end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        resp_en = 1'b0;
        @(negedge clock);
        @(negedge clock);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        #1;
        vectors++;
        if (bus.imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rd_redirect_cycle_req: got %b expected 0", bus.imem_req_valid);
        end
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        resp_en            = 1'b1;
        #1;
        vectors++;
        if (dut.state !== DRAIN) begin
            miscompares++;
            $display("[TB] FAIL rd_state: got %0d expected DRAIN", dut.state);
        end
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge clock);
                #1;
            end
            vectors++;
            if (bus.imem_req_valid !== 1'b0 || bus.instr_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL rd_drain[%0d]: got req %b ivalid %b expected 0 0",
                         k, bus.imem_req_valid, bus.instr_valid);
            end
        end
        @(negedge clock);
        #1;
        vectors++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_0100) begin
            miscompares++;
            $display("[TB] FAIL rd_new_req: got valid %b addr %h expected 1 00000100",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        @(negedge clock);
        #1;
        vectors++;
        if (bus.imem_req_addr !== 32'h0000_0104 || bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rd_second_req: got addr %h ivalid %b expected 00000104 0",
                     bus.imem_req_addr, bus.instr_valid);
        end
        @(negedge clock);
        #1;
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0000_0100 || bus.instr !== memword(32'h100)) begin
            miscompares++;
            $display("[TB] FAIL rd_first_instr: got v %b pc %h instr %h expected 1 00000100 %h",
                     bus.instr_valid, bus.instr_pc, bus.instr, memword(32'h100));
        end
    endtask

    task automatic test_redirect_twice();
        do_reset();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0203;
        #1;
        vectors++;
        if (bus.imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rt_redirect_req: got %b expected 0", bus.imem_req_valid);
        end
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        resp_en            = 1'b0;
        #1;
        vectors++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_0200) begin
            miscompares++;
            $display("[TB] FAIL rt_aligned_req: got valid %b addr %h expected 1 00000200",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        @(negedge clock);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0180;
        @(negedge clock);
        bus.redirect_pc    = 32'h0000_0300;
        #1;
        vectors++;
        if (dut.state !== DRAIN || bus.imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rt_drain_redirect: got state %0d req %b expected DRAIN 0",
                     dut.state, bus.imem_req_valid);
        end
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        resp_en            = 1'b1;
        @(negedge clock);
        #1;
        vectors++;
        if (bus.imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rt_still_drain: got %b expected 0", bus.imem_req_valid);
        end
        @(negedge clock);
        #1;
        vectors++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_0300) begin
            miscompares++;
            $display("[TB] FAIL rt_last_pc_wins: got valid %b addr %h expected 1 00000300",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        repeat (2) @(negedge clock);
        #1;
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0000_0300) begin
            miscompares++;
            $display("[TB] FAIL rt_first_instr: got v %b pc %h expected 1 00000300",
                     bus.instr_valid, bus.instr_pc);
        end
        @(negedge clock);
        #1;
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0000_0304) begin
            miscompares++;
            $display("[TB] FAIL rt_second_instr: got v %b pc %h expected 1 00000304",
                     bus.instr_valid, bus.instr_pc);
        end
    endtask

    task automatic test_redirect_collide();
        do_reset();
        repeat (3) @(negedge clock);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0400;
        #1;
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h4 || bus.imem_req_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rc_pre: got v %b pc %h req %b expected 1 00000004 0",
                     bus.instr_valid, bus.instr_pc, bus.imem_req_valid);
        end
        @(negedge clock);
        bus.redirect_valid = 1'b0;
        #1;
        vectors++;
        if (bus.instr_valid !== 1'b0 || dut.state !== RUN) begin
            miscompares++;
            $display("[TB] FAIL rc_flushed: got v %b state %0d expected 0 RUN", bus.instr_valid, dut.state);
        end
        vectors++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0000_0400) begin
            miscompares++;
            $display("[TB] FAIL rc_new_req: got valid %b addr %h expected 1 00000400",
                     bus.imem_req_valid, bus.imem_req_addr);
        end
        @(negedge clock);
        #1;
        vectors++;
        if (bus.instr_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rc_no_stale: got v %b pc %h expected 0", bus.instr_valid, bus.instr_pc);
        end
        @(negedge clock);
        #1;
        vectors++;
        if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0000_0400 || bus.instr !== memword(32'h400)) begin
            miscompares++;
            $display("[TB] FAIL rc_first_instr: got v %b pc %h instr %h expected 1 00000400 %h",
                     bus.instr_valid, bus.instr_pc, bus.instr, memword(32'h400));
        end
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_perf();
        do_reset();
        resp_en = 1'b0;
        #1;
        vectors++;
        if (stall_cycles !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL perf_reset: got %0d expected 0", stall_cycles);
        end
        repeat (5) @(negedge clock);
        resp_en = 1'b1;
        #1;
        vectors++;
        if (stall_cycles !== 32'd5) begin
            miscompares++;
            $display("[TB] FAIL perf_five: got %0d expected 5", stall_cycles);
        end
        repeat (3) @(negedge clock);
        #1;
        vectors++;
        if (stall_cycles !== 32'd7 || bus.instr_valid !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL perf_stop: got %0d v %b expected 7 1", stall_cycles, bus.instr_valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drain();
        test_redirect_twice();
        test_redirect_collide();
`ifdef FETCH_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
